// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame length and serf state encoding
package spi_pkg;

    // Frame length shared with the monarch side of the link.
    localparam int SPI_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2
    } serf_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - multi-flop synchronizer with rise/fall detection
module spi_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              dly;

    // Synchronizer chain followed by one delay flop used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {STAGES{RST_VAL}};
            dly  <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            dly  <= sync[STAGES-1];
        end
    end

    // The level is taken from the delay flop so it changes in the same cycle
    // the consumer acts on the corresponding edge event.
    assign level = dly;
    assign rise  = sync[STAGES-1] & ~dly;
    assign fall  = ~sync[STAGES-1] & dly;

endmodule

// File: rtl/spi_serf.sv
// rtl/spi_serf.sv - SPI serf endpoint shifting one frame per SS_n low period
module spi_serf
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic             wrt,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             done,
    output logic             busy,
    output logic             frame_err
);

    // Count saturates at WIDTH+1 so overlong frames stay distinguishable.
    localparam int CW = $clog2(WIDTH + 2);

    serf_state_t      state, state_n;
    logic [WIDTH-1:0] hold_reg, hold_n;
    logic [WIDTH-1:0] shift_reg, shift_n;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] rx_n;
    logic [CW-1:0]    count, count_n;
    logic             smpl, smpl_n;
    logic             done_n;
    logic             err_n;

    logic ss_level, ss_rise, ss_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic [SYNC_STAGES:0] mosi_sync;
    logic mosi;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SS_n),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SCLK),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // MOSI gets the same depth as the edge paths so data lines up with sclk_rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-1:0], MOSI};
        end
    end

    assign mosi    = mosi_sync[SYNC_STAGES];
    assign shifted = {shift_reg[WIDTH-2:0], smpl};
    assign MISO    = shift_reg[WIDTH-1];
    assign busy    = ~ss_level;

    // State register and all frame datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_reg  <= '0;
            shift_reg <= '0;
            count     <= '0;
            smpl      <= 1'b0;
            rx_data   <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            hold_reg  <= hold_n;
            shift_reg <= shift_n;
            count     <= count_n;
            smpl      <= smpl_n;
            rx_data   <= rx_n;
            done      <= done_n;
            frame_err <= err_n;
        end
    end

    // Next-state and datapath update; ss_rise takes priority over SCLK edges.
    always_comb begin
        state_n = state;
        hold_n  = wrt ? tx_data : hold_reg;
        shift_n = shift_reg;
        count_n = count;
        smpl_n  = smpl;
        rx_n    = rx_data;
        done_n  = 1'b0;
        err_n   = wrt ? 1'b0 : frame_err;

        case (state)
            IDLE: begin
                if (ss_fall) begin
                    shift_n = wrt ? tx_data : hold_reg;
                    count_n = '0;
                    state_n = FRONT;
                end
            end
            FRONT: begin
                if (ss_rise) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (sclk_rise) begin
                    smpl_n  = mosi;
                    count_n = count + 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    shift_n = shifted;
                    state_n = IDLE;
                    if (count == CW'(WIDTH)) begin
                        rx_n   = shifted;
                        done_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (sclk_fall) begin
                    shift_n = shifted;
                end else if (sclk_rise) begin
                    smpl_n = mosi;
                    if (count != CW'(WIDTH + 1)) begin
                        count_n = count + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_serf.sv
// tb/tb_spi_serf.sv - randomized self-checking bench for spi_serf
module tb_spi_serf;
    import spi_pkg::*;

    localparam int W = SPI_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         SS_n = 1'b1;
    logic         SCLK = 1'b1;
    logic         MOSI = 1'b0;
    logic         MISO;
    logic         wrt = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic [W-1:0] rx_data;
    logic         done;
    logic         busy;
    logic         frame_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // Reference model: hold word, last received word, sticky error.
    logic [W-1:0] m_hold = '0;
    logic [W-1:0] m_rx = '0;
    logic         m_err = 1'b0;

    spi_serf #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .wrt       (wrt),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .done      (done),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [W-1:0] v);
        tx_data = v;
        wrt = 1'b1;
        tick(1);
        wrt = 1'b0;
        m_hold = v;
        m_err = 1'b0;
    endtask

    // Monarch: MOSI changes on SCLK fall, MISO sampled on SCLK rise,
    // a leading data-less fall, no trailing fall after the last bit.
    task automatic frame(input logic [W-1:0] mo, input int nbits, input int wrt_at,
                         input logic [W-1:0] wrt_val, output logic [W-1:0] mi);
        logic [W-1:0] sh;
        sh = mo;
        mi = '0;
        check("busy_before", busy, 0);
        SS_n = 1'b0;
        tick(16);
        check("busy_during", busy, 1);
        if (nbits > 0) begin
            SCLK = 1'b0;
            MOSI = sh[W-1];
            tick(16);
            for (int i = 0; i < nbits; i++) begin
                SCLK = 1'b1;
                mi = {mi[W-2:0], MISO};
                if (i == wrt_at) begin
                    load(wrt_val);
                    tick(15);
                end else begin
                    tick(16);
                end
                if (i < nbits - 1) begin
                    SCLK = 1'b0;
                    sh = sh << 1;
                    MOSI = sh[W-1];
                    tick(16);
                end
            end
            tick(16);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick(16);
    endtask

    task automatic run(input string tag, input logic [W-1:0] mo, input int nbits,
                       input int wrt_at, input logic [W-1:0] wrt_val);
        logic [W-1:0] start_hold;
        logic [W-1:0] mi;
        int d0;
        start_hold = m_hold;
        d0 = done_cnt;
        frame(mo, nbits, wrt_at, wrt_val, mi);
        if (nbits == W) begin
            check({tag, " miso_word"}, mi, start_hold);
            m_rx = mo;
        end else begin
            m_err = 1'b1;
        end
        check({tag, " rx_data"}, rx_data, m_rx);
        check({tag, " frame_err"}, frame_err, m_err);
        check({tag, " done_pulses"}, done_cnt - d0, (nbits == W) ? 1 : 0);
        check({tag, " busy_after"}, busy, 0);
    endtask

    initial begin
        int nb;
        int wa;
        tick(3);
        check("rst MISO", MISO, 0);
        check("rst rx_data", rx_data, 0);
        check("rst done", done, 0);
        check("rst busy", busy, 0);
        check("rst frame_err", frame_err, 0);
        rst_n = 1'b1;
        tick(3);

        load(16'hA5C3);
        run("basic", 16'h1234, W, -1, '0);

        load(16'h8000);
        run("b2b_1", 16'hFFFF, W, -1, '0);
        load(16'h7FFE);
        run("b2b_2", 16'h0001, W, -1, '0);

        load(16'hF00F);
        run("mid_wrt", 16'hAAAA, W, 5, 16'h00FF);
        run("after_mid", 16'h5555, W, -1, '0);

        run("trunc", 16'h3C3C, 8, -1, '0);
        load(16'h1111);
        check("err_cleared_by_wrt", frame_err, 0);

        run("no_sclk", 16'h0000, 0, -1, '0);

        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 1) == 1) load(W'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                nb = $urandom_range(0, 18);
                if (nb == W) nb = W + 1;
            end else begin
                nb = W;
            end
            wa = (nb > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            run("rand", W'($urandom), nb, wa, W'($urandom));
        end

        // Leave frame_err set so the reset clearing it is observable.
        run("pre_rst", 16'h0000, 0, -1, '0);

        SS_n = 1'b0;
        tick(16);
        SCLK = 1'b0;
        MOSI = 1'b1;
        tick(16);
        for (int i = 0; i < 9; i++) begin
            SCLK = 1'b1;
            tick(16);
            SCLK = 1'b0;
            tick(16);
        end
        SCLK = 1'b1;
        rst_n = 1'b0;
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick(2);
        check("midrst MISO", MISO, 0);
        check("midrst rx_data", rx_data, 0);
        check("midrst done", done, 0);
        check("midrst busy", busy, 0);
        check("midrst frame_err", frame_err, 0);
        tick(3);
        rst_n = 1'b1;
        tick(3);
        m_hold = '0;
        m_rx = '0;
        m_err = 1'b0;
        done_cnt = 0;
        run("after_rst", 16'hBEEF, W, -1, '0);
        load(16'hC0DE);
        run("after_rst_2", 16'h600D, W, -1, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
